// File: rtl/sudoku_btn_conditioner.sv
// Push-button conditioner for the sudoku solver front panel: synchronise, debounce,
// one-cycle pulse per press, auto-repeat on Prev/Next, Start overrides the rest.
module sudoku_btn_conditioner #(
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 20000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BtnPrev,
    input  logic BtnNext,
    input  logic BtnEnter,
    input  logic BtnStart,
    output logic Prev,
    output logic Next,
    output logic Enter,
    output logic Start,
    output logic Busy
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 32;

    localparam int unsigned CH_PREV  = 0;
    localparam int unsigned CH_NEXT  = 1;
    localparam int unsigned CH_ENTER = 2;
    localparam int unsigned CH_START = 3;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEB_PRESS,
        ST_PULSE,
        ST_HELD,
        ST_DEB_REL
    } state_e;

    logic [NCH-1:0] raw_c;
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] pulse_c;
    logic [NCH-1:0] active_c;

    logic prev_q;
    logic next_q;
    logic enter_q;
    logic start_q;
    logic busy_q;

    assign raw_c = {BtnStart, BtnEnter, BtnNext, BtnPrev};

    // Two-flop synchroniser per raw button.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        localparam bit IS_REPEAT = (ch == CH_PREV) || (ch == CH_NEXT);

        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             rep_q;
        logic             rep_d;
        logic             s_c;

        assign s_c = sync2_q[ch];

        always_ff @(posedge Clk) begin
            if (Reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                rep_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rep_q   <= rep_d;
            end
        end

        // rep_q selects the short repeat period once a repeat pulse has fired.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rep_d   = rep_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (s_c) begin
                        state_d = ST_DEB_PRESS;
                        cnt_d   = '0;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!s_c) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = ST_PULSE;
                        rep_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PULSE: begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end
                ST_HELD: begin
                    if (!s_c) begin
                        state_d = ST_DEB_REL;
                        cnt_d   = '0;
                    end else if (IS_REPEAT &&
                                 (cnt_q == (rep_q ? PERIOD_LAST : DELAY_LAST))) begin
                        state_d = ST_PULSE;
                        rep_d   = 1'b1;
                    end else if (IS_REPEAT || (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DEB_REL: begin
                    if (s_c) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rep_d   = 1'b0;
                end
            endcase
        end

        assign pulse_c[ch]  = (state_d == ST_PULSE);
        assign active_c[ch] = (state_d != ST_IDLE);
    end

    // Output flops load together with the PULSE state; Start masks the others.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_q  <= 1'b0;
            next_q  <= 1'b0;
            enter_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= pulse_c[CH_START];
            prev_q  <= pulse_c[CH_PREV]  & ~pulse_c[CH_START];
            next_q  <= pulse_c[CH_NEXT]  & ~pulse_c[CH_START];
            enter_q <= pulse_c[CH_ENTER] & ~pulse_c[CH_START];
            busy_q  <= |active_c;
        end
    end

    assign Prev  = prev_q;
    assign Next  = next_q;
    assign Enter = enter_q;
    assign Start = start_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_sudoku_btn_conditioner.sv
// Self-checking bench for sudoku_btn_conditioner with short debounce/repeat counts.
// Expected pulses are queued as ch*M+cycle when stimulus is applied; the clock task logs observed ones.
module tb_sudoku_btn_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned RDL = 16;
    localparam int unsigned RPR = 8;
    localparam int M = 1000000;

    logic clk;
    logic reset;
    logic btn_prev, btn_next, btn_enter, btn_start;
    logic prev, next, enter, start, busy;

    int cyc;
    int checks;
    int failures;
    int exp_q[$];
    int obs_q[$];

    sudoku_btn_conditioner #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (RDL),
        .REPEAT_PERIOD(RPR)
    ) dut (
        .Clk     (clk),
        .Reset   (reset),
        .BtnPrev (btn_prev),
        .BtnNext (btn_next),
        .BtnEnter(btn_enter),
        .BtnStart(btn_start),
        .Prev    (prev),
        .Next    (next),
        .Enter   (enter),
        .Start   (start),
        .Busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // One clock; cyc is the index of the edge just taken, outputs logged as events.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev === 1'b1)  obs_q.push_back(0 * M + cyc);
        if (next === 1'b1)  obs_q.push_back(1 * M + cyc);
        if (enter === 1'b1) obs_q.push_back(2 * M + cyc);
        if (start === 1'b1) obs_q.push_back(3 * M + cyc);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic quiesce();
        btn_prev  = 1'b0;
        btn_next  = 1'b0;
        btn_enter = 1'b0;
        btn_start = 1'b0;
        reset     = 1'b0;
        run(12);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        btn_prev  = 1'b0;
        btn_next  = 1'b0;
        btn_enter = 1'b0;
        btn_start = 1'b0;
        reset     = 1'b1;
        tick();
        checks++;
        if ({prev, next, enter, start, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00000", {prev, next, enter, start, busy});
        end
        tick();
        reset = 1'b0;
        run(3);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_no_pulse: got %0d events expected 0", obs_q.size());
        end
    endtask

    task automatic test_enter_single();
        int t0;
        int lat;
        quiesce();
        t0 = cyc + 1;
        btn_enter = 1'b1;
        exp_q.push_back(2 * M + t0 + 6);
        run(40);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL enter_busy_held: got %b expected 1", busy);
        end
        btn_enter = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (busy === 1'b0) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat < 1 || lat > 7) begin
            failures++;
            $display("FAIL enter_busy_release: got %0d cycles expected 1..7", lat);
        end
        run(5);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL enter_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL enter_event[%0d]: got %0d expected %0d", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        quiesce();
        pat = 7'b1110110;
        for (int i = 6; i >= 0; i--) begin
            btn_next = pat[i];
            tick();
        end
        btn_next = 1'b0;
        run(15);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bounce_busy: got %b expected 0", busy);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL bounce_count: got %0d expected 0", obs_q.size());
        end
    endtask

    task automatic test_next_repeat();
        int t0;
        quiesce();
        t0 = cyc + 1;
        btn_next = 1'b1;
        exp_q.push_back(1 * M + t0 + 6);
        exp_q.push_back(1 * M + t0 + 6 + 17);
        exp_q.push_back(1 * M + t0 + 6 + 26);
        exp_q.push_back(1 * M + t0 + 6 + 35);
        exp_q.push_back(1 * M + t0 + 6 + 44);
        run(55);
        btn_next = 1'b0;
        run(30);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL repeat_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL repeat_event[%0d]: got %0d expected %0d", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_priority();
        int t0;
        quiesce();
        // Start and Enter together: Enter's pulse is lost.
        t0 = cyc + 1;
        btn_start = 1'b1;
        btn_enter = 1'b1;
        exp_q.push_back(3 * M + t0 + 6);
        run(25);
        btn_start = 1'b0;
        btn_enter = 1'b0;
        run(15);
        // Start and Next together: Next's first pulse is lost, its repeat is not shifted.
        t0 = cyc + 1;
        btn_start = 1'b1;
        btn_next  = 1'b1;
        exp_q.push_back(3 * M + t0 + 6);
        exp_q.push_back(1 * M + t0 + 6 + 17);
        run(30);
        btn_start = 1'b0;
        btn_next  = 1'b0;
        run(20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL start_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL start_event[%0d]: got %0d expected %0d", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_release_glitch();
        int t0;
        quiesce();
        t0 = cyc + 1;
        btn_prev = 1'b1;
        exp_q.push_back(0 * M + t0 + 6);
        run(10);
        btn_prev = 1'b0;
        run(2);
        btn_prev = 1'b1;
        // HELD restarts at edge 14 with the initial delay still pending.
        exp_q.push_back(0 * M + t0 + 30);
        run(21);
        btn_prev = 1'b0;
        run(20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL glitch_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL glitch_event[%0d]: got %0d expected %0d", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int t0;
        int t1;
        quiesce();
        t0 = cyc + 1;
        btn_next = 1'b1;
        exp_q.push_back(1 * M + t0 + 6);
        run(10);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_busy_before: got %b expected 1", busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({prev, next, enter, start, busy} !== 5'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got %b expected 00000", {prev, next, enter, start, busy});
        end
        reset = 1'b0;
        t1 = cyc + 1;
        exp_q.push_back(1 * M + t1 + 6);
        run(10);
        btn_next = 1'b0;
        run(20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL midreset_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL midreset_event[%0d]: got %0d expected %0d", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        reset     = 1'b1;
        btn_prev  = 1'b0;
        btn_next  = 1'b0;
        btn_enter = 1'b0;
        btn_start = 1'b0;
        test_reset();
        test_enter_single();
        test_bounce();
        test_next_repeat();
        test_start_priority();
        test_release_glitch();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
